// File: rtl/mac_pe_sequencer.sv
// Operand-side sequencer for a single MAC PE. It streams N operand pairs into the PE,
// reads back the accumulated dot product and returns it over a valid/ready result port.
module mac_pe_sequencer #(
    parameter int InputDataWidth  = 8,
    parameter int OutputDataWidth = InputDataWidth * 2,
    parameter int CountWidth      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [CountWidth-1:0]      len_i,
    output logic                       busy_o,
    input  logic [InputDataWidth-1:0]  op_a_i,
    input  logic [InputDataWidth-1:0]  op_b_i,
    input  logic                       op_valid_i,
    output logic                       op_ready_o,
    output logic [InputDataWidth-1:0]  pe_a_o,
    output logic [InputDataWidth-1:0]  pe_b_o,
    output logic                       pe_a_valid_o,
    output logic                       pe_b_valid_o,
    output logic                       pe_acc_clr_o,
    input  logic [OutputDataWidth-1:0] pe_acc_i,
    output logic [OutputDataWidth-1:0] res_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [CountWidth-1:0]   len_reg;
    logic [CountWidth-1:0]   cnt_reg;
    logic                    settle_reg;
    logic                    beat;

    assign beat = op_valid_i && op_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            settle_reg   <= 1'b0;
            busy_o       <= 1'b0;
            op_ready_o   <= 1'b0;
            pe_a_o       <= '0;
            pe_b_o       <= '0;
            pe_a_valid_o <= 1'b0;
            pe_b_valid_o <= 1'b0;
            pe_acc_clr_o <= 1'b0;
            res_o        <= '0;
            res_valid_o  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            len_reg    <= len_i;
                            cnt_reg    <= '0;
                            op_ready_o <= 1'b1;
                            state_reg  <= STREAM;
                        end else begin
                            // Empty job: answer zero without touching the PE.
                            res_o       <= '0;
                            res_valid_o <= 1'b1;
                            state_reg   <= RESULT;
                        end
                    end
                end
                STREAM: begin
                    if (beat) begin
                        pe_a_o       <= op_a_i;
                        pe_b_o       <= op_b_i;
                        pe_a_valid_o <= 1'b1;
                        pe_b_valid_o <= 1'b1;
                        pe_acc_clr_o <= (cnt_reg == '0);
                        cnt_reg      <= cnt_reg + CountWidth'(1);
                        if (cnt_reg == len_reg - CountWidth'(1)) begin
                            op_ready_o <= 1'b0;
                            state_reg  <= DRAIN;
                        end
                    end else begin
                        pe_a_valid_o <= 1'b0;
                        pe_b_valid_o <= 1'b0;
                        pe_acc_clr_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    pe_a_valid_o <= 1'b0;
                    pe_b_valid_o <= 1'b0;
                    pe_acc_clr_o <= 1'b0;
                    settle_reg   <= 1'b0;
                    state_reg    <= CAPTURE;
                end
                CAPTURE: begin
                    // acc_o reflects the last pair one cycle after the PE samples it,
                    // so the capture waits a single settle cycle.
                    if (!settle_reg) begin
                        settle_reg <= 1'b1;
                    end else begin
                        res_o       <= pe_acc_i;
                        res_valid_o <= 1'b1;
                        state_reg   <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe_sequencer.sv
// Directed bench for mac_pe_sequencer with a behavioural MAC PE and a result scoreboard.
// Expected sums are pushed when a job starts; a monitor pops them on each result handshake.
module tb_mac_pe_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  len_i;
    logic        busy_o;
    logic [7:0]  op_a_i;
    logic [7:0]  op_b_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [7:0]  pe_a_o;
    logic [7:0]  pe_b_o;
    logic        pe_a_valid_o;
    logic        pe_b_valid_o;
    logic        pe_acc_clr_o;
    logic [15:0] pe_acc_i;
    logic [15:0] res_o;
    logic        res_valid_o;
    logic        res_ready_i;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    mac_pe_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .pe_a_o(pe_a_o), .pe_b_o(pe_b_o), .pe_a_valid_o(pe_a_valid_o),
        .pe_b_valid_o(pe_b_valid_o), .pe_acc_clr_o(pe_acc_clr_o), .pe_acc_i(pe_acc_i),
        .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
    );

    // Behavioural PE: accumulator register followed by an output register.
    logic [15:0] pe_acc_int = '0;
    initial pe_acc_i = '0;
    always @(posedge clk_i) begin
        if (pe_acc_clr_o)
            pe_acc_int <= 16'(pe_a_o * pe_b_o);
        else if (pe_a_valid_o)
            pe_acc_int <= pe_acc_int + 16'(pe_a_o * pe_b_o);
        pe_acc_i <= pe_acc_int;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Result monitor: pops the scoreboard on every handshake.
    always @(negedge clk_i) begin
        if (!rst_i && res_valid_o && res_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL res_unexpected got=%0d want=none", res_o);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (res_o !== e) begin
                    miscompares++;
                    $display("FAIL res_value got=%0d want=%0d", res_o, e);
                end else begin
                    $display("result %0d ok", res_o);
                end
            end
        end
        if (!rst_i && pe_a_valid_o)
            check("pe_b_valid_eq", {31'd0, pe_b_valid_o}, 32'd1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            step();
            n++;
        end
        check("wait_idle_busy", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic start_job(input logic [7:0] n);
        start_i = 1'b1;
        len_i   = n;
        step();
        start_i = 1'b0;
        len_i   = 8'hxx;
    endtask

    // Feeds one pair; returns after the accepting edge (+1).
    task automatic feed(input logic [7:0] a, input logic [7:0] b, input bit first);
        int t = 0;
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        @(negedge clk_i);
        while (!op_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("op_ready_timeout", {31'd0, op_ready_o}, 32'd1);
        step();
        op_valid_i = 1'b0;
        check("pe_a", {24'd0, pe_a_o}, {24'd0, a});
        check("pe_b", {24'd0, pe_b_o}, {24'd0, b});
        check("pe_valid", {31'd0, pe_a_valid_o}, 32'd1);
        check("pe_clr", {31'd0, pe_acc_clr_o}, {31'd0, first});
    endtask

    task automatic run_job(input int n, input logic [7:0] av[4], input logic [7:0] bv[4],
                           input int gap, input logic [15:0] expv, input bit check_lat);
        exp_q.push_back(expv);
        start_job(8'(n));
        for (int i = 0; i < n; i++) begin
            feed(av[i], bv[i], i == 0);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("gap_valid_low", {31'd0, pe_a_valid_o}, 32'd0);
                end
            end
        end
        if (check_lat) begin
            int k = 0;
            while (!res_valid_o && k < 10) begin
                step();
                k++;
            end
            check("result_latency", 32'(k), 32'd3);
        end
        wait_idle();
    endtask

    logic [7:0] a1[4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    logic [7:0] b1[4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    logic [7:0] a2[4] = '{8'd10, 8'd1, 8'd0, 8'd0};
    logic [7:0] a3[4] = '{8'd2, 8'd4, 8'd6, 8'd0};
    logic [7:0] b3[4] = '{8'd3, 8'd5, 8'd7, 8'd0};
    logic [7:0] a4[4] = '{8'd255, 8'd255, 8'd0, 8'd0};
    logic [7:0] a5[4] = '{8'd3, 8'd0, 8'd0, 8'd0};

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; op_a_i = '0; op_b_i = '0;
        op_valid_i = 1'b0; res_ready_i = 1'b1;
        repeat (3) step();
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, op_ready_o}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_res", {16'd0, res_o}, 32'd0);
        check("rst_pe_valid", {30'd0, pe_a_valid_o, pe_b_valid_o}, 32'd0);
        rst_i = 1'b0;
        step();

        run_job(4, a1, b1, 0, 16'd100, 1'b1);
        run_job(2, a2, a2, 0, 16'd101, 1'b0);
        run_job(3, a3, b3, 2, 16'd68, 1'b0);
        run_job(2, a4, a4, 0, 16'd64514, 1'b0);

        // Empty job: result on the next edge, PE untouched.
        exp_q.push_back(16'd0);
        start_job(8'd0);
        check("len0_res_valid", {31'd0, res_valid_o}, 32'd1);
        check("len0_pe_ctrl", {29'd0, pe_a_valid_o, pe_b_valid_o, pe_acc_clr_o}, 32'd0);
        wait_idle();
        check("len0_pe_ctrl_after", {29'd0, pe_a_valid_o, pe_b_valid_o, pe_acc_clr_o}, 32'd0);

        // Back-pressure on the result port; start_i must be ignored meanwhile.
        res_ready_i = 1'b0;
        exp_q.push_back(16'd100);
        start_job(8'd4);
        for (int i = 0; i < 4; i++) feed(a1[i], b1[i], i == 0);
        begin
            int k = 0;
            while (!res_valid_o && k < 10) begin step(); k++; end
        end
        start_i = 1'b1;
        len_i   = 8'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_res", {16'd0, res_o}, 32'd100);
            check("hold_valid", {31'd0, res_valid_o}, 32'd1);
            check("hold_busy", {31'd0, busy_o}, 32'd1);
        end
        start_i = 1'b0;
        res_ready_i = 1'b1;
        step();
        check("after_hold_busy", {31'd0, busy_o}, 32'd0);
        check("after_hold_ready", {31'd0, op_ready_o}, 32'd0);

        // Reset in the middle of a stream, then a fresh one-beat job.
        start_job(8'd4);
        feed(8'd1, 8'd2, 1'b1);
        feed(8'd3, 8'd4, 1'b0);
        rst_i = 1'b1;
        step();
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_ready", {31'd0, op_ready_o}, 32'd0);
        check("midrst_pe", {13'd0, pe_a_valid_o, pe_b_valid_o, pe_acc_clr_o, pe_a_o, pe_b_o}, 32'd0);
        check("midrst_res", {15'd0, res_valid_o, res_o}, 32'd0);
        rst_i = 1'b0;
        step();
        run_job(1, a5, a5, 0, 16'd9, 1'b0);

        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
